// File: rtl/water_led_flow.sv
// Running-light controller: prescaled step strobe drives a rotating / ping-pong / blinking LED pattern.
// Define WATER_LED_PINGPONG_EN to build the ping-pong direction logic; otherwise mode 10 rotates left.
module water_led_flow #(
  parameter int               LED_NUM        = 4,
  parameter int               CNT_W          = 25,
  parameter logic [CNT_W-1:0] CNT_MAX        = 25'd24_999_999,
  parameter bit               LED_ACTIVE_LOW = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [1:0]         mode,
  input  logic               pause,
  output logic [LED_NUM-1:0] led_out,
  output logic               step_pulse
);

  typedef enum logic [1:0] {
    MODE_ROL   = 2'b00,
    MODE_ROR   = 2'b01,
    MODE_PING  = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  localparam logic [LED_NUM-1:0] ONE_HOT0 = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] ALL_ONES = '1;

  function automatic logic [LED_NUM-1:0] drive(input logic [LED_NUM-1:0] p);
    return LED_ACTIVE_LOW ? ~p : p;
  endfunction

  logic [CNT_W-1:0]   cnt;
  logic [LED_NUM-1:0] pat;
  logic [LED_NUM-1:0] pat_nxt;
  logic [LED_NUM-1:0] pat_rol;
  logic [LED_NUM-1:0] pat_ror;
  logic               pat_onehot;
  logic               step;

`ifdef WATER_LED_PINGPONG_EN
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  dir_e dir, dir_nxt;
`endif

  assign step       = (cnt == CNT_MAX) && !pause;
  assign pat_rol    = {pat[LED_NUM-2:0], pat[LED_NUM-1]};
  assign pat_ror    = {pat[0], pat[LED_NUM-1:1]};
  assign pat_onehot = (pat != '0) && ((pat & (pat - ONE_HOT0)) == '0);

  // Prescaler: pause freezes the count where it is.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (!pause) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_comb begin
    pat_nxt = pat;
`ifdef WATER_LED_PINGPONG_EN
    dir_nxt = dir;
`endif
    if (step) begin
      // Leaving blink with a non-one-hot pattern restarts the walk from bit0.
      if (mode_e'(mode) != MODE_BLINK && !pat_onehot) begin
        pat_nxt = ONE_HOT0;
`ifdef WATER_LED_PINGPONG_EN
        dir_nxt = DIR_UP;
`endif
      end else begin
        case (mode_e'(mode))
          MODE_ROL: pat_nxt = pat_rol;
          MODE_ROR: pat_nxt = pat_ror;
          MODE_PING: begin
`ifdef WATER_LED_PINGPONG_EN
            // Bounce off the ends without dwelling: an end bit reverses immediately.
            if (dir == DIR_UP) begin
              if (pat[LED_NUM-1]) begin
                pat_nxt = pat >> 1;
                dir_nxt = DIR_DOWN;
              end else begin
                pat_nxt = pat << 1;
                if (pat[LED_NUM-2]) dir_nxt = DIR_DOWN;
              end
            end else begin
              if (pat[0]) begin
                pat_nxt = pat << 1;
                dir_nxt = DIR_UP;
              end else begin
                pat_nxt = pat >> 1;
                if (pat[1]) dir_nxt = DIR_UP;
              end
            end
`else
            pat_nxt = pat_rol;
`endif
          end
          default: pat_nxt = (pat == ALL_ONES) ? '0 : ALL_ONES;
        endcase
      end
    end
  end

  // led_out is registered from pat_nxt so it shows the new pattern on the same edge as pat.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pat        <= ONE_HOT0;
      led_out    <= drive(ONE_HOT0);
      step_pulse <= 1'b0;
    end else begin
      pat        <= pat_nxt;
      led_out    <= drive(pat_nxt);
      step_pulse <= step;
    end
  end

`ifdef WATER_LED_PINGPONG_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) dir <= DIR_UP;
    else            dir <= dir_nxt;
  end
`endif

endmodule

// File: tb/tb_water_led_flow.sv
// Scoreboard bench for water_led_flow: expected LED steps and step gaps are queued, then
// popped and compared on each step_pulse.
module tb_water_led_flow;
  localparam int N = 4;

  logic         sys_clk   = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         pause     = 1'b0;
  logic [1:0]   mode      = 2'b00;
  logic [N-1:0] led_out;
  logic         step_pulse;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] led;
    int           gap;
  } exp_t;
  exp_t sb[$];

  water_led_flow #(
    .LED_NUM(N), .CNT_W(25), .CNT_MAX(25'd24), .LED_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode(mode), .pause(pause),
    .led_out(led_out), .step_pulse(step_pulse)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] led, input int gap);
    exp_t e;
    e.led = led;
    e.gap = gap;
    sb.push_back(e);
  endtask

  // Counts negedges until step_pulse; led_out must stay put meanwhile.
  task automatic wait_step(output int gap, output bit held, output bit tmo);
    logic [N-1:0] prev;
    prev = led_out;
    gap  = 0;
    held = 1'b1;
    tmo  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      gap++;
      if (step_pulse) begin
        tmo = 1'b0;
        break;
      end
      if (led_out !== prev) held = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    int   gap;
    bit   held, tmo;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_step(gap, held, tmo);
      chk({tag, "_timeout"}, 32'(tmo), 32'(0));
      chk({tag, "_hold"}, 32'(held), 32'(1));
      chk({tag, "_led"}, 32'(led_out), 32'(e.led));
      chk({tag, "_gap"}, 32'(gap), 32'(e.gap));
    end
  endtask

  // Idles n cycles, clearing quiet if led_out moves or step_pulse fires.
  task automatic idle(input int n, inout bit quiet);
    logic [N-1:0] prev;
    prev = led_out;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (led_out !== prev || step_pulse) quiet = 1'b0;
    end
  endtask

  task automatic do_reset(input logic [1:0] m, input string tag);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    mode      = m;
    #1;
    chk({tag, "_rst_led"}, 32'(led_out), 32'(4'b1110));
    chk({tag, "_rst_pulse"}, 32'(step_pulse), 32'(0));
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    bit quiet;

    // Reset state and first step latency
    #15;
    chk("t1_rst_led", 32'(led_out), 32'(4'b1110));
    chk("t1_rst_pulse", 32'(step_pulse), 32'(0));
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    push(4'b1101, 25);
    drain("t1");
    @(negedge sys_clk);
    chk("t1_pulse_once", 32'(step_pulse), 32'(0));

    // Rotate left continues (one cycle already consumed above)
    push(4'b1011, 24);
    push(4'b0111, 25);
    push(4'b1110, 25);
    drain("t2_rol");

    // Rotate right from reset
    do_reset(2'b01, "t2_ror");
    push(4'b0111, 25);
    push(4'b1011, 25);
    push(4'b1101, 25);
    push(4'b1110, 25);
    drain("t2_ror");

    // Ping-pong from reset
    do_reset(2'b10, "t3");
`ifdef WATER_LED_PINGPONG_EN
    push(4'b1101, 25);
    push(4'b1011, 25);
    push(4'b0111, 25);
    push(4'b1011, 25);
    push(4'b1101, 25);
    push(4'b1110, 25);
    push(4'b1101, 25);
`else
    push(4'b1101, 25);
    push(4'b1011, 25);
    push(4'b0111, 25);
    push(4'b1110, 25);
    push(4'b1101, 25);
    push(4'b1011, 25);
    push(4'b0111, 25);
`endif
    drain("t3");

    // Blink, then leave blink while all LEDs are lit
    do_reset(2'b11, "t4");
    push(4'b0000, 25);
    push(4'b1111, 25);
    push(4'b0000, 25);
    drain("t4_blink");
    mode = 2'b00;
    push(4'b1110, 25);
    push(4'b1101, 25);
    drain("t4_exit");

    // Pause at cnt=10 for 100 clocks, with mode toggled between steps
    quiet = 1'b1;
    idle(5, quiet);
    mode = 2'b01;
    idle(5, quiet);
    pause = 1'b1;
    idle(50, quiet);
    mode = 2'b00;
    idle(30, quiet);
    mode = 2'b01;
    idle(20, quiet);
    mode = 2'b00;
    chk("t5_pause_quiet", 32'(quiet), 32'(1));
    pause = 1'b0;
    push(4'b1011, 15);
    drain("t5");

    // Async reset mid-count while showing 1011
    quiet = 1'b1;
    idle(7, quiet);
    chk("t6_pre_led", 32'(led_out), 32'(4'b1011));
    #5;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_async_led", 32'(led_out), 32'(4'b1110));
    chk("t6_async_pulse", 32'(step_pulse), 32'(0));
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    push(4'b1101, 25);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
